// File: rtl/ssd_pkg.sv
// ssd_pkg: shared types and constants for the seven-segment scanner
//   seg7_t    : active-low segment vector {g,f,e,d,c,b,a}
//   SEG_BLANK : all segments off
//   AN_OFF    : all anodes off
//   HEX_SEG   : hex nibble -> active-low segment pattern
package ssd_pkg;
  typedef logic [6:0] seg7_t;
  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam seg7_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: valid/ready load port carrying a packed hex word and dp mask
//   load_valid : master -> slave, load request
//   load_ready : slave -> master, request accepted when valid && ready
//   load_data  : master -> slave, nibble k drives digit k
//   load_dp    : master -> slave, decimal-point mask (1 = lit)
interface seven_seg_scanner_if #(parameter int NUM_DIGITS = 8);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]   load_dp;
  modport master (output load_valid, load_data, load_dp, input load_ready);
  modport slave (input load_valid, load_data, load_dp, output load_ready);
endinterface

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low seven-segment pattern
//   i_nib : nibble to display
//   o_seg : active-low {g,f,e,d,c,b,a}
module hex_to_seg7
  import ssd_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg7_t      o_seg
);
  assign o_seg = HEX_SEG[i_nib];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a common-anode 8-digit seven-segment display
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   ld        : load port (slave), new word takes effect at the next frame boundary
//   digit_en  : live per-digit enable (0 = digit dark)
//   an_n      : active-low anodes, unused bits held high
//   seg_n     : active-low segments {g,f,e,d,c,b,a}
//   dp_n      : active-low decimal point
//   digit_idx : digit currently scanned
//   Define SSD_LZB_EN to enable leading-zero blanking.
module seven_seg_scanner
  import ssd_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int FRAME_HZ   = 1_000,
  parameter int NUM_DIGITS = 8,
  parameter int BLANK_CYC  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scanner_if.slave    ld,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [7:0]            an_n,
  output seg7_t                 seg_n,
  output logic                  dp_n,
  output logic [2:0]            digit_idx
);
  localparam int DIV = CLK_HZ / (FRAME_HZ * NUM_DIGITS);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  if (DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= DIV || NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_cfg
    $error("seven_seg_scanner: illegal DIV/BLANK_CYC/NUM_DIGITS");
  end
  logic [CW-1:0]           r_cnt;
  logic [2:0]              r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp, r_shadow;
  logic [NUM_DIGITS-1:0]   r_dp, r_sdp;
  logic                    r_pend;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_last_cnt, w_wrap, w_acc;
  logic [31:0]             w_disp32;
  logic [7:0]              w_dp8, w_en8, w_lz8;
  logic [3:0]              w_nib;
  seg7_t                   w_seg;
  assign w_last_cnt   = r_cnt == CW'(DIV - 1);
  assign w_wrap       = w_last_cnt && (r_idx == 3'(NUM_DIGITS - 1));
  assign ld.load_ready = !r_pend;
  assign w_acc        = ld.load_valid && !r_pend;
  // Widen per-digit vectors to the full 8-digit range so the 3-bit index always fits.
  assign w_disp32 = 32'(r_disp);
  assign w_dp8    = 8'(r_dp);
  assign w_en8    = 8'(digit_en);
  assign w_lz8    = 8'(w_lz);
  assign w_nib    = w_disp32[{r_idx, 2'b00} +: 4];
  hex_to_seg7 u_hex (.i_nib(w_nib), .o_seg(w_seg));
`ifdef SSD_LZB_EN
  logic w_zr;
  // Running AND of "nibble is zero" from the top digit down; digit 0 is never blanked.
  always_comb begin
    w_lz = '0;
    w_zr = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_zr    = w_zr && (r_disp[4*k +: 4] == 4'h0);
      w_lz[k] = w_zr;
    end
  end
`else
  assign w_lz = '0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_disp    <= '0;
      r_shadow  <= '0;
      r_dp      <= '0;
      r_sdp     <= '0;
      r_pend    <= 1'b0;
      an_n      <= AN_OFF;
      seg_n     <= SEG_BLANK;
      dp_n      <= 1'b1;
      digit_idx <= '0;
    end else begin
      r_cnt <= w_last_cnt ? '0 : r_cnt + 1'b1;
      if (w_last_cnt) r_idx <= w_wrap ? 3'd0 : r_idx + 3'd1;
      // A load landing on the wrap edge skips the shadow and shows from the next frame.
      if (w_wrap && w_acc) begin
        r_disp <= ld.load_data;
        r_dp   <= ld.load_dp;
      end else if (w_wrap && r_pend) begin
        r_disp <= r_shadow;
        r_dp   <= r_sdp;
        r_pend <= 1'b0;
      end else if (w_acc) begin
        r_shadow <= ld.load_data;
        r_sdp    <= ld.load_dp;
        r_pend   <= 1'b1;
      end
      // Outputs trail the scan state by one edge so slot k covers edges k*DIV+1..(k+1)*DIV.
      an_n      <= (32'(r_cnt) < BLANK_CYC || !w_en8[r_idx]) ? AN_OFF : ~(8'd1 << r_idx);
      seg_n     <= w_lz8[r_idx] ? SEG_BLANK : w_seg;
      dp_n      <= !w_dp8[r_idx];
      digit_idx <= r_idx;
    end
  end
endmodule
